// File: rtl/rr_arbiter_16.sv
// rr_arbiter_16: sixteen-requester rotating-priority arbiter.
// The highest index wins relative to a rotating pointer. The last winner drops to
// lowest priority. A grant is held until done, until the winner withdraws its
// request, or until the hold limit forces release. All outputs are registered.

module rr_arbiter_16 #(
  parameter int unsigned MAX_HOLD = 64,
  parameter int unsigned HOLD_W   = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en,
  input  logic [15:0] req,
  input  logic        done,
  output logic [15:0] grant,
  output logic [3:0]  gnt_id,
  output logic        gnt_valid,
  output logic        timeout
);

  typedef enum logic {StIdle, StBusy} state_e;

  state_e            state;
  logic [3:0]        ptr;
  logic [HOLD_W-1:0] hold_cnt;

  logic [3:0] win_id;
  logic       win_found;
  logic [3:0] idx;
  logic       early_rel;
  logic       hold_limit;

  // Scan the request vector from ptr downward, wrapping at 0, and take the first hit.
  always_comb begin
    win_id    = 4'd0;
    win_found = 1'b0;
    idx       = 4'd0;
    for (int i = 0; i < 16; i++) begin
      idx = ptr - 4'(i);
      if (!win_found && req[idx]) begin
        win_found = 1'b1;
        win_id    = idx;
      end
    end
  end

  // Release conditions. done or a withdrawn request suppresses the timeout flag.
  always_comb begin
    early_rel  = done || !req[gnt_id];
    hold_limit = (hold_cnt == HOLD_W'(MAX_HOLD - 1));
  end

  // FSM with registered grant outputs and the rotating pointer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= StIdle;
      grant     <= '0;
      gnt_id    <= '0;
      gnt_valid <= 1'b0;
      timeout   <= 1'b0;
      hold_cnt  <= '0;
      ptr       <= 4'd15;
    end else begin
      timeout <= 1'b0;
      unique case (state)
        StIdle: begin
          if (en && win_found) begin
            state     <= StBusy;
            grant     <= 16'(1) << win_id;
            gnt_id    <= win_id;
            gnt_valid <= 1'b1;
            hold_cnt  <= '0;
          end
        end
        StBusy: begin
          if (early_rel || hold_limit) begin
            state     <= StIdle;
            grant     <= '0;
            gnt_id    <= '0;
            gnt_valid <= 1'b0;
            timeout   <= !early_rel;
            hold_cnt  <= '0;
            // Last winner becomes lowest priority.
            ptr       <= gnt_id - 4'd1;
          end else begin
            hold_cnt <= hold_cnt + HOLD_W'(1);
          end
        end
        default: state <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_rr_arbiter_16.sv
// Testbench for rr_arbiter_16: directed scenarios with literal expectations, then
// randomized traffic checked every cycle against a behavioural model.

module tb_rr_arbiter_16;

  localparam int unsigned MaxHold = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        en = 1'b0;
  logic [15:0] req = '0;
  logic        done = 1'b0;
  logic [15:0] grant;
  logic [3:0]  gnt_id;
  logic        gnt_valid;
  logic        timeout;

  int total = 0;
  int bad = 0;

  rr_arbiter_16 #(
    .MAX_HOLD(MaxHold),
    .HOLD_W  (16)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .en       (en),
    .req      (req),
    .done     (done),
    .grant    (grant),
    .gnt_id   (gnt_id),
    .gnt_valid(gnt_valid),
    .timeout  (timeout)
  );

  always #5 clk = ~clk;

  // Behavioural model: who holds the grant, for how many visible cycles, and the
  // client that currently has top priority.
  int m_ptr  = 15;
  bit m_busy = 1'b0;
  int m_id   = 0;
  int m_held = 0;
  bit m_to   = 1'b0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_ptr  = 15;
      m_busy = 1'b0;
      m_id   = 0;
      m_held = 0;
      m_to   = 1'b0;
    end else if (m_busy) begin
      m_to = 1'b0;
      if (done || !req[m_id]) begin
        m_busy = 1'b0;
        m_ptr  = (m_id + 15) % 16;
      end else if (m_held == MaxHold) begin
        m_busy = 1'b0;
        m_ptr  = (m_id + 15) % 16;
        m_to   = 1'b1;
      end else begin
        m_held++;
      end
    end else begin
      m_to = 1'b0;
      if (en && req != 16'h0) begin
        for (int k = 0; k < 16; k++) begin
          int c;
          c = (m_ptr - k + 16) % 16;
          if (!m_busy && req[c]) begin
            m_busy = 1'b1;
            m_id   = c;
            m_held = 1;
          end
        end
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    logic [15:0] eg;
    eg = m_busy ? (16'h1 << m_id) : 16'h0;
    check("grant", 32'(grant), 32'(eg));
    check("gnt_id", 32'(gnt_id), m_busy ? 32'(m_id) : 32'd0);
    check("gnt_valid", 32'(gnt_valid), 32'(m_busy));
    check("timeout", 32'(timeout), 32'(m_to));
    check("onehot", 32'($onehot0(grant)), 32'd1);
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pulse_reset();
    rst_n = 1'b0;
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    int rot [5] = '{15, 10, 5, 0, 15};
    #1 rst_n = 1'b0;
    cyc(2);
    check("reset_grant", 32'(grant), 32'h0);
    check("reset_valid", 32'(gnt_valid), 32'h0);

    // Reset and first grant.
    en = 1'b1;
    req = 16'h8001;
    rst_n = 1'b1;
    cyc(1);
    check("first_grant", 32'(grant), 32'h8000);
    check("first_id", 32'(gnt_id), 32'd15);
    done = 1'b1;
    cyc(1);
    check("first_release", 32'(grant), 32'h0);
    done = 1'b0;

    // Rotation from a fresh pointer.
    pulse_reset();
    req = 16'h8421;
    for (int i = 0; i < 5; i++) begin
      cyc(1);
      check("rotation_id", 32'(gnt_id), 32'(rot[i]));
      done = 1'b1;
      cyc(1);
      check("rotation_gap", 32'(gnt_valid), 32'h0);
      done = 1'b0;
    end

    // Withdrawal by the winner.
    req = 16'h0080;
    cyc(1);
    check("withdraw_id", 32'(gnt_id), 32'd7);
    req = 16'h0000;
    cyc(1);
    check("withdraw_grant", 32'(grant), 32'h0);
    check("withdraw_to", 32'(timeout), 32'h0);
    req = 16'hFFFF;
    cyc(1);
    check("withdraw_ptr", 32'(gnt_id), 32'd6);
    done = 1'b1;
    cyc(1);
    done = 1'b0;
    req = 16'h0010;

    // Hold limit.
    for (int i = 0; i < 4; i++) begin
      cyc(1);
      check("hold_grant", 32'(grant), 32'h0010);
      check("hold_to", 32'(timeout), 32'h0);
    end
    cyc(1);
    check("limit_grant", 32'(grant), 32'h0);
    check("limit_to", 32'(timeout), 32'h1);
    cyc(1);
    check("regrant", 32'(grant), 32'h0010);
    check("regrant_to", 32'(timeout), 32'h0);
    req = 16'h0000;
    cyc(2);

    // Enable gating.
    pulse_reset();
    en = 1'b0;
    req = 16'hFFFF;
    cyc(3);
    check("en_off", 32'(grant), 32'h0);
    en = 1'b1;
    cyc(1);
    check("en_on", 32'(grant), 32'h8000);
    en = 1'b0;
    cyc(2);
    check("en_drop_hold", 32'(grant), 32'h8000);
    done = 1'b1;
    cyc(1);
    check("en_drop_rel", 32'(grant), 32'h0);
    done = 1'b0;
    cyc(3);
    check("en_drop_none", 32'(gnt_valid), 32'h0);

    // Asynchronous reset mid-grant.
    pulse_reset();
    en = 1'b1;
    req = 16'h0200;
    cyc(1);
    check("async_pre", 32'(gnt_id), 32'd9);
    #2 rst_n = 1'b0;
    #1;
    check("async_grant", 32'(grant), 32'h0);
    check("async_valid", 32'(gnt_valid), 32'h0);
    check("async_id", 32'(gnt_id), 32'h0);
    req = 16'h0201;
    cyc(1);
    rst_n = 1'b1;
    cyc(1);
    check("async_after", 32'(gnt_id), 32'd9);
    done = 1'b1;
    cyc(1);
    done = 1'b0;

    // Randomized traffic against the model.
    for (int n = 0; n < 3000; n++) begin
      cyc(1);
      en = ($urandom_range(0, 3) != 0);
      done = ($urandom_range(0, 4) == 0);
      if ($urandom_range(0, 1) == 0) begin
        case ($urandom_range(0, 2))
          0: req = 16'($urandom) & 16'($urandom) & 16'($urandom);
          1: req = 16'($urandom);
          default: req = 16'h1 << $urandom_range(0, 15);
        endcase
      end
      if ($urandom_range(0, 499) == 0) begin
        #1 pulse_reset();
      end
    end
    cyc(2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/rr_arbiter_16.md
# rr_arbiter_16

Sixteen-requester rotating-priority arbiter for sharing one downstream resource (bus slot, shared datapath unit) among up to 16 clients. It uses the same convention as the team's 16x4 priority encoder: the highest index wins. Priority then rotates so that the last winner drops to lowest priority. Each grant is held until the winner signals completion, withdraws its request, or a hold-limit counter forces release. The block sits between the request sources and the shared resource and produces a one-hot grant plus the encoded winner index.

## Interface
- MAX_HOLD, default 64: maximum cycles a grant may be held before forced release (legal range 2..65535).
- HOLD_W, default 16: width of the internal hold counter; must satisfy 2^HOLD_W >= MAX_HOLD.

- clk  in  1  system clock; all state updates on the rising edge.
- rst_n  in  1  reset, asynchronous and active-low.
- en  in  1  arbitration enable; 0 blocks new grants, while a grant in progress runs to completion.
- req  in  16  request vector; bit k = client k requests.
- done  in  1  winner finished; sampled only while gnt_valid=1.
- grant  out  16  one-hot grant, registered; all zero when idle.
- gnt_id  out  4  encoded index of the granted client, registered; 0 when idle.
- gnt_valid  out  1  a grant is active.
- timeout  out  1  one-cycle pulse on the cycle a grant is force-released by the hold limit.

## Operation
- State machine with two states, IDLE and BUSY. Reset state is IDLE.
- Reset values: grant=0, gnt_id=0, gnt_valid=0, timeout=0, hold counter=0, pointer ptr=15.
- Search order: ptr, ptr-1, …, 0, 15, …, ptr+1 (mod 16). The first requesting index in this order wins.
  - With ptr=15, this is plain highest-index-first priority encoding.
- IDLE behaviour:
  - If en=1 and req!=0: register the winner into grant/gnt_id, set gnt_valid=1, clear the hold counter, and go to BUSY.
  - Otherwise stay in IDLE with all outputs zero.
- BUSY behaviour: the hold counter increments every cycle. Release occurs on the first of these conditions:
  - done=1;
  - req[gnt_id]=0 (requester withdrew);
  - hold counter = MAX_HOLD-1, which also sets timeout=1 for that one cycle.
- On release:
  - grant, gnt_id and gnt_valid clear;
  - ptr becomes gnt_id-1 mod 16 (granting client 0 sets ptr=15);
  - state returns to IDLE.
- Simultaneous release conditions: done or a withdrawn request takes precedence over timeout, so timeout=0 if done=1 on the limit cycle.
- Requests that change while BUSY have no effect on the current grant, except withdrawal by the winner.
- en falling while BUSY: the grant continues until a normal release. No new grant is issued while en=0.
- Asynchronous reset mid-grant: all outputs clear immediately and ptr returns to 15.

## Timing
- Request-to-grant latency is 1 cycle. If req is sampled non-zero in IDLE at edge N, then grant, gnt_id and gnt_valid are valid after edge N.
- Release latency is 1 cycle. If done=1 is sampled at edge M, then grant=0 after edge M.
- There is exactly one idle cycle between consecutive grants; the next arbitration uses the updated ptr.
- With no done, a grant lasts exactly MAX_HOLD cycles. timeout is high in the cycle after the last held cycle, aligned with grant falling, and lasts 1 cycle.
- grant is always one-hot or zero, and gnt_id always matches grant.
- All outputs come straight from registers, with no combinational path from input to output.

## Test plan
- Reset and first grant: release reset with req=16'h8001, en=1 → after 1 cycle, grant=16'h8000, gnt_id=15; done pulse → grant=0 the next cycle.
- Rotation: hold req=16'h8421 constant and pulse done after each grant → grant order 15, 10, 5, 0, 15, with ptr wrapping correctly.
- Withdrawal: client 7 granted with req=16'h0080, then drop req to 0 → grant clears the next cycle, timeout=0, and ptr=6.
- Hold limit: MAX_HOLD=4, req=16'h0010, done held 0 → grant high for 4 cycles, then timeout=1 for 1 cycle with grant=0. Re-grant to 4 follows one cycle later, since it is the only requester.
- Enable gating: en=0 with req=16'hFFFF → no grant. Set en=1 → grant=16'h8000. Drop en mid-grant → grant holds until done, then no new grant.
- Async reset mid-grant: assert rst_n=0 while gnt_id=9 → outputs zero immediately without a clock edge. After release with req=16'h0201, the winner is 9 (ptr reset to 15).
